control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer.sv | 141 ++++++++++++++
 tb/tb_control_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer: fetch (T0-T2), decode/execute (T3-T5) with a
// memory wait state in T1, a sticky HALT and a completed-ALU-instruction counter.
module control_sequencer (
    input  logic        clock,
    input  logic        clear,
    input  logic        run,
    input  logic        mem_ready,
    input  logic [31:0] IR,
    output logic [31:0] Rout,
    output logic [31:0] Rin,
    output logic        IRin,
    output logic        MARin,
    output logic        RYin,
    output logic        MDRread,
    output logic        RZout,
    output logic        RBin,
    output logic        PCjump,
    output logic [15:0] ALUControl,
    output logic        busy,
    output logic        halted,
    output logic        illegal,
    output logic [15:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_HALT
    } state_t;

    localparam int unsigned ZLOW_BIT = 19;
    localparam int unsigned PC_BIT   = 20;
    localparam int unsigned MDR_BIT  = 21;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_instr_count;

    logic [4:0]  w_opcode;
    logic [3:0]  w_ra;
    logic [3:0]  w_rb;
    logic [3:0]  w_rc;
    logic        w_is_alu;
    logic        w_is_halt;
    logic        w_is_nop;
    logic        w_unused;

    assign w_opcode  = IR[31:27];
    assign w_ra      = IR[26:23];
    assign w_rb      = IR[22:19];
    assign w_rc      = IR[18:15];
    assign w_unused  = ^IR[14:0];
    assign w_is_alu  = (w_opcode >= 5'd1) && (w_opcode <= 5'd8);
    assign w_is_halt = (w_opcode == 5'd31);
    assign w_is_nop  = (w_opcode == 5'd0);

    always_ff @(posedge clock) begin
        if (clear) begin
            r_state       <= S_IDLE;
            r_instr_count <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_T5) begin
                r_instr_count <= r_instr_count + 16'd1;
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        Rout       = '0;
        Rin        = '0;
        IRin       = 1'b0;
        MARin      = 1'b0;
        RYin       = 1'b0;
        MDRread    = 1'b0;
        ALUControl = '0;
        illegal    = 1'b0;
        unique case (r_state)
            S_IDLE: w_next = run ? S_T0 : S_IDLE;
            S_T0: begin
                Rout[PC_BIT]  = 1'b1;
                MARin         = 1'b1;
                Rin[ZLOW_BIT] = 1'b1;
                w_next        = S_T1;
            end
            // PC reload is held off until the read completes so wait states
            // do not advance the PC more than once.
            S_T1: begin
                Rout[ZLOW_BIT] = 1'b1;
                MDRread        = 1'b1;
                Rin[MDR_BIT]   = 1'b1;
                Rin[PC_BIT]    = mem_ready;
                w_next         = mem_ready ? S_T2 : S_T1;
            end
            S_T2: begin
                Rout[MDR_BIT] = 1'b1;
                IRin          = 1'b1;
                w_next        = S_T3;
            end
            S_T3: begin
                if (w_is_alu) begin
                    Rout   = 32'd1 << w_rb;
                    RYin   = 1'b1;
                    w_next = S_T4;
                end else if (w_is_halt) begin
                    w_next = S_HALT;
                end else begin
                    illegal = !w_is_nop;
                    w_next  = run ? S_T0 : S_IDLE;
                end
            end
            S_T4: begin
                Rout          = 32'd1 << w_rc;
                Rin[ZLOW_BIT] = 1'b1;
                ALUControl    = 16'(w_opcode) + 16'd11;
                w_next        = S_T5;
            end
            S_T5: begin
                Rout[ZLOW_BIT] = 1'b1;
                Rin            = 32'd1 << w_ra;
                w_next         = run ? S_T0 : S_IDLE;
            end
            S_HALT: w_next = S_HALT;
            default: w_next = S_IDLE;
        endcase
    end

    assign RZout       = 1'b0;
    assign RBin        = 1'b0;
    assign PCjump      = 1'b0;
    assign busy        = (r_state != S_IDLE) && (r_state != S_HALT);
    assign halted      = (r_state == S_HALT);
    assign instr_count = r_instr_count;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer: fetch/execute strobes,
// wait states, illegal/NOP/HALT handling, clear priority and counter wrap.
module tb_control_sequencer;

    logic        clock = 1'b0;
    logic        clear;
    logic        run;
    logic        mem_ready;
    logic [31:0] IR;
    logic [31:0] Rout;
    logic [31:0] Rin;
    logic        IRin;
    logic        MARin;
    logic        RYin;
    logic        MDRread;
    logic        RZout;
    logic        RBin;
    logic        PCjump;
    logic [15:0] ALUControl;
    logic        busy;
    logic        halted;
    logic        illegal;
    logic [15:0] instr_count;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned pc_pulses;
    logic        mon_en = 1'b0;
    logic [105:0] all_out;

    control_sequencer dut (
        .clock      (clock),
        .clear      (clear),
        .run        (run),
        .mem_ready  (mem_ready),
        .IR         (IR),
        .Rout       (Rout),
        .Rin        (Rin),
        .IRin       (IRin),
        .MARin      (MARin),
        .RYin       (RYin),
        .MDRread    (MDRread),
        .RZout      (RZout),
        .RBin       (RBin),
        .PCjump     (PCjump),
        .ALUControl (ALUControl),
        .busy       (busy),
        .halted     (halted),
        .illegal    (illegal),
        .instr_count(instr_count)
    );

    always #5 clock = ~clock;

    assign all_out = {Rout, Rin, IRin, MARin, RYin, MDRread, RZout, RBin, PCjump,
                      ALUControl, busy, halted, illegal, instr_count};

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // strobes = {IRin, MARin, RYin, MDRread}
    task automatic chk_strobes(input string tag, input logic [31:0] e_rout,
                               input logic [31:0] e_rin, input logic [3:0] e_str,
                               input logic [15:0] e_alu);
        chk({tag, "_rout"}, 128'(Rout), 128'(e_rout));
        chk({tag, "_rin"}, 128'(Rin), 128'(e_rin));
        chk({tag, "_str"}, 128'({IRin, MARin, RYin, MDRread}), 128'(e_str));
        chk({tag, "_alu"}, 128'(ALUControl), 128'(e_alu));
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        if (mon_en) begin
            chk("rout_onehot0", 128'($onehot0(Rout)), 128'(1));
        end
    end

    initial begin
        clear     = 1'b1;
        run       = 1'b0;
        mem_ready = 1'b1;
        IR        = '0;
        tick();
        tick();
        clear = 1'b0;
        tick();
        mon_en = 1'b1;
        chk("reset_all_zero", 128'(all_out), 128'(0));

        // SUB R2 <- R5 - R6, full fetch and execute
        run = 1'b1;
        IR  = 32'h112B_0000;
        tick();
        chk_strobes("t0", 32'h0010_0000, 32'h0008_0000, 4'b0100, 16'd0);
        chk("t0_busy", 128'(busy), 128'(1));
        tick();
        chk_strobes("t1", 32'h0008_0000, 32'h0030_0000, 4'b0001, 16'd0);
        tick();
        chk_strobes("t2", 32'h0020_0000, 32'h0000_0000, 4'b1000, 16'd0);
        tick();
        chk_strobes("t3_sub", 32'h0000_0020, 32'h0000_0000, 4'b0010, 16'd0);
        tick();
        chk_strobes("t4_sub", 32'h0000_0040, 32'h0008_0000, 4'b0000, 16'd13);
        tick();
        chk_strobes("t5_sub", 32'h0008_0000, 32'h0000_0004, 4'b0000, 16'd0);
        chk("t5_count_before", 128'(instr_count), 128'(0));
        run = 1'b0;
        tick();
        chk("sub_count", 128'(instr_count), 128'(1));
        chk("sub_idle_busy", 128'(busy), 128'(0));

        // Three memory wait states in T1
        run       = 1'b1;
        mem_ready = 1'b0;
        pc_pulses = 0;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wait_rout", 128'(Rout), 128'(32'h0008_0000));
            chk("wait_rin", 128'(Rin), 128'(32'h0020_0000));
            pc_pulses += int'(Rin[20]);
        end
        mem_ready = 1'b1;
        #1;
        chk("wait_ready_rin", 128'(Rin), 128'(32'h0030_0000));
        pc_pulses += int'(Rin[20]);
        tick();
        chk("wait_t2_irin", 128'(IRin), 128'(1));
        pc_pulses += int'(Rin[20]);
        chk("pcin_pulses", 128'(pc_pulses), 128'(1));
        run = 1'b0;
        tick();
        tick();
        tick();
        tick();
        chk("wait_count", 128'(instr_count), 128'(2));

        // Illegal opcode 01100 then NOP
        run = 1'b1;
        IR  = 32'h6000_0000;
        tick(); tick(); tick(); tick();
        chk("ill_t3_pulse", 128'(illegal), 128'(1));
        chk("ill_t3_rout", 128'(Rout), 128'(0));
        chk("ill_t3_ryin", 128'(RYin), 128'(0));
        tick();
        chk("ill_next_t0", 128'(MARin), 128'(1));
        chk("ill_cleared", 128'(illegal), 128'(0));
        chk("ill_count", 128'(instr_count), 128'(2));
        run = 1'b0;
        IR  = 32'h0000_0000;
        tick(); tick(); tick();
        chk("nop_t3_strobes", 128'({Rout, Rin, IRin, MARin, RYin, MDRread, illegal}), 128'(0));
        chk("nop_t3_busy", 128'(busy), 128'(1));
        tick();
        chk("nop_to_idle", 128'(busy), 128'(0));

        // ADD R7 <- R7 + R7, run dropped in T4
        run = 1'b1;
        IR  = 32'h0BBB_8000;
        tick(); tick(); tick(); tick();
        chk_strobes("t3_add", 32'h0000_0080, 32'h0, 4'b0010, 16'd0);
        tick();
        chk_strobes("t4_add", 32'h0000_0080, 32'h0008_0000, 4'b0000, 16'd12);
        run = 1'b0;
        tick();
        chk_strobes("t5_add", 32'h0008_0000, 32'h0000_0080, 4'b0000, 16'd0);
        tick();
        chk("drop_idle_busy", 128'(busy), 128'(0));
        chk("drop_count", 128'(instr_count), 128'(3));

        // clear during T4
        run = 1'b1;
        tick(); tick(); tick(); tick(); tick();
        chk("pre_clear_alu", 128'(ALUControl), 128'(16'd12));
        clear = 1'b1;
        tick();
        chk("clear_t4_all", 128'(all_out), 128'(0));
        clear = 1'b0;
        run   = 1'b0;
        tick();
        chk("clear_t4_stay_idle", 128'(all_out), 128'(0));

        // HALT
        run = 1'b1;
        IR  = 32'hF800_0000;
        tick(); tick(); tick(); tick();
        chk("halt_t3_strobes", 128'({Rout, Rin, RYin, illegal}), 128'(0));
        tick();
        chk("halt_halted", 128'(halted), 128'(1));
        chk("halt_busy", 128'(busy), 128'(0));
        chk("halt_rout", 128'(Rout), 128'(0));
        run = 1'b0;
        tick();
        chk("halt_run0", 128'(halted), 128'(1));
        run = 1'b1;
        tick();
        chk("halt_run1", 128'(halted), 128'(1));
        chk("halt_run1_busy", 128'(busy), 128'(0));
        clear = 1'b1;
        tick();
        chk("halt_clear_all", 128'(all_out), 128'(0));
        clear = 1'b0;
        run   = 1'b0;

        // clear while waiting in T1
        run       = 1'b1;
        mem_ready = 1'b0;
        tick(); tick(); tick();
        chk("t1w_rout", 128'(Rout), 128'(32'h0008_0000));
        clear = 1'b1;
        tick();
        chk("t1w_clear_all", 128'(all_out), 128'(0));
        clear     = 1'b0;
        run       = 1'b0;
        mem_ready = 1'b1;

        // Counter wrap: preload 0xFFFF and complete one ADD
        IR = 32'h0BBB_8000;
        force dut.r_instr_count = 16'hFFFF;
        #1;
        release dut.r_instr_count;
        #1;
        chk("wrap_preload", 128'(instr_count), 128'(16'hFFFF));
        run = 1'b1;
        tick();
        run = 1'b0;
        tick(); tick(); tick(); tick(); tick();
        chk("wrap_t5_count", 128'(instr_count), 128'(16'hFFFF));
        tick();
        chk("wrap_count", 128'(instr_count), 128'(0));
        chk("wrap_idle", 128'(busy), 128'(0));

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
